// File: rtl/i2c_master_cmd_if.sv
// i2c_master_cmd_if: command/response handshake between a controller and the I2C command engine.
interface i2c_master_cmd_if #(
    parameter int p_WORD_LEN = 8
);
    logic [1:0]            inp_cmd;
    logic [p_WORD_LEN-1:0] inp_data;
    logic                  inp_ack;
    logic                  inp_en;
    logic                  inp_rdy;
    logic [p_WORD_LEN-1:0] out_data;
    logic                  out_ack;
    logic                  out_err;
    logic                  out_rdy;
    logic                  out_busy;

    modport master (
        output inp_cmd, inp_data, inp_ack, inp_en,
        input  inp_rdy, out_data, out_ack, out_err, out_rdy, out_busy
    );

    modport slave (
        input  inp_cmd, inp_data, inp_ack, inp_en,
        output inp_rdy, out_data, out_ack, out_err, out_rdy, out_busy
    );
endinterface

// File: rtl/i2c_master_cmd.sv
// i2c_master_cmd: command-driven single-master I2C engine (START/WRITE/READ/STOP, open-drain pins).
// Define I2C_CLK_STRETCH_EN to let slaves stretch SCL in the high quarter q1.
module i2c_master_cmd #(
    parameter int p_WORD_LEN = 8,
    parameter int p_CLK_DIV  = 250
) (
    input  logic i_clk,
    input  logic i_rstn,
    inout  wire  io_sda,
    inout  wire  io_scl,
    i2c_master_cmd_if.slave bus
);
    localparam int DW = $clog2(p_CLK_DIV);
    localparam int BW = $clog2(p_WORD_LEN + 1);
    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [1:0]            qtr_q, qtr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [p_WORD_LEN-1:0] sh_q, sh_d, data_q, data_d;
    logic [1:0]            cmd_q, cmd_d;
    logic                  ack_q, ack_d, samp_q, samp_d, oack_q, oack_d;
    logic                  err_q, err_d, busy_q, busy_d;
    logic                  sda_low_q, sda_low_d, scl_low_q, scl_low_d;
    logic [1:0]            sda_s_q;
    logic                  active, rdy, accept, hold, tick, qend, last_bit;

    assign io_sda = sda_low_q ? 1'b0 : 1'bz;
    assign io_scl = scl_low_q ? 1'b0 : 1'bz;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) sda_s_q <= 2'b11;
        else         sda_s_q <= {sda_s_q[0], io_sda};
    end

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_s_q;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) scl_s_q <= 2'b11;
        else         scl_s_q <= {scl_s_q[0], io_scl};
    end
    // q1 may not end until the released SCL is actually seen high
    assign hold = (qtr_q == 2'd1) && !scl_s_q[1];
`else
    assign hold = 1'b0;
`endif

    assign active   = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_ACK) || (state_q == S_STOP);
    assign rdy      = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept   = bus.inp_en && rdy;
    assign tick     = active && (div_q == DW'(p_CLK_DIV - 1)) && !hold;
    assign qend     = tick && (qtr_q == 2'd3);
    assign last_bit = bit_q == BW'(p_WORD_LEN - 1);

    assign bus.inp_rdy  = rdy;
    assign bus.out_data = data_q;
    assign bus.out_ack  = oack_q;
    assign bus.out_err  = err_q;
    assign bus.out_rdy  = state_q == S_DONE;
    assign bus.out_busy = busy_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            cmd_q     <= CMD_START;
            ack_q     <= 1'b0;
            samp_q    <= 1'b0;
            oack_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            sda_low_q <= 1'b0;
            scl_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            cmd_q     <= cmd_d;
            ack_q     <= ack_d;
            samp_q    <= samp_d;
            oack_q    <= oack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            sda_low_q <= sda_low_d;
            scl_low_q <= scl_low_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        ack_d   = ack_q;
        oack_d  = oack_q;
        err_d   = err_q;
        busy_d  = busy_q;
        div_d   = (!active || tick) ? '0 : (div_q == DW'(p_CLK_DIV - 1)) ? div_q : div_q + 1'b1;
        qtr_d   = !active ? 2'd0 : qtr_q + {1'b0, tick};
        samp_d  = (tick && qtr_q == 2'd2) ? sda_s_q[1] : samp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    cmd_d   = bus.inp_cmd;
                    sh_d    = bus.inp_data;
                    ack_d   = bus.inp_ack;
                    bit_d   = '0;
                    err_d   = (bus.inp_cmd != CMD_START) && !busy_q;
                    state_d = err_d ? S_DONE :
                              (bus.inp_cmd == CMD_START) ? S_START :
                              (bus.inp_cmd == CMD_STOP)  ? S_STOP  : S_BIT;
                end
            end
            S_START: begin
                if (qend) begin
                    state_d = S_DONE;
                    busy_d  = 1'b1;
                end
            end
            S_BIT: begin
                if (qend) begin
                    sh_d  = {sh_q[p_WORD_LEN-2:0], samp_q};
                    bit_d = bit_q + 1'b1;
                    if (last_bit) begin
                        state_d = S_ACK;
                        data_d  = (cmd_q == CMD_READ) ? {sh_q[p_WORD_LEN-2:0], samp_q} : data_q;
                    end
                end
            end
            S_ACK: begin
                if (tick && qtr_q == 2'd2 && cmd_q == CMD_WRITE) oack_d = sda_s_q[1];
                if (qend) state_d = S_DONE;
            end
            S_STOP: begin
                if (qend) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Between commands an owned bus is stalled: SCL low, SDA frozen at its last level
        scl_low_d = (state_q == S_START) ? ((qtr_q == 2'd0) ? busy_q : (qtr_q == 2'd3)) :
                    (state_q == S_STOP)  ? (qtr_q == 2'd0) :
                    (state_q == S_BIT || state_q == S_ACK) ? (qtr_q == 2'd0 || qtr_q == 2'd3) :
                    busy_q;
        sda_low_d = (state_q == S_START) ? qtr_q[1] :
                    (state_q == S_STOP)  ? !qtr_q[1] :
                    (state_q == S_BIT)   ? (cmd_q == CMD_WRITE && !sh_q[p_WORD_LEN-1]) :
                    (state_q == S_ACK)   ? (cmd_q == CMD_READ && !ack_q) :
                    busy_q && sda_low_q;
    end
endmodule

// File: tb/tb_i2c_master_cmd.sv
// tb_i2c_master_cmd: table-driven command vectors with an SDA-bit scoreboard and a behavioural slave.
module tb_i2c_master_cmd;
    logic clk, rstn;
    wire  sda, scl;
    logic slv_low, scl_slv, slv_rd, slv_ack, sb_en;
    logic [7:0] slv_byte;
    event slv_kick;
    int   checks, errors, starts, stops, edges;
    bit   expq[$];
    bit   obsq[$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] din;
        logic       ain;
        logic       sack;
        logic [7:0] sbyte;
        logic [7:0] edata;
        logic       eack;
        logic       eerr;
        logic       ebusy;
        int         elat;
    } vec_t;

    vec_t vecs[16];

    i2c_master_cmd_if #(.p_WORD_LEN(8)) bus();

    i2c_master_cmd #(.p_WORD_LEN(8), .p_CLK_DIV(4)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .io_sda(sda),
        .io_scl(scl),
        .bus   (bus)
    );

    pullup (sda);
    pullup (scl);
    assign sda = slv_low ? 1'b0 : 1'bz;
    assign scl = scl_slv ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge scl) if (sb_en) obsq.push_back(sda);
    always @(negedge sda) if (scl === 1'b1) starts++;
    always @(posedge sda) if (scl === 1'b1) stops++;
    always @(sda or scl) edges++;

    // Slave: presents a read byte or an ACK, stepping on each SCL falling edge
    initial begin
        slv_low = 1'b0;
        forever begin
            @(slv_kick);
            if (slv_rd) slv_low = ~slv_byte[7];
            for (int k = 1; k <= 9; k++) begin
                @(negedge scl);
                if (slv_rd) slv_low = (k < 8) ? ~slv_byte[7-k] : 1'b0;
                else        slv_low = (k == 8) ? slv_ack : 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int tol);
        int n, s0, p0, e0;
        bit e, o;
        expq.delete();
        obsq.delete();
        chk("inp_rdy", bus.inp_rdy, 1);
        s0 = starts; p0 = stops; e0 = edges;
        bus.inp_cmd  = v.cmd;
        bus.inp_data = v.din;
        bus.inp_ack  = v.ain;
        bus.inp_en   = 1'b1;
        if (!v.eerr && (v.cmd == 2'd1 || v.cmd == 2'd2)) begin
            for (int i = 7; i >= 0; i--) expq.push_back(v.cmd == 2'd1 ? v.din[i] : v.sbyte[i]);
            expq.push_back(v.cmd == 2'd1 ? !v.sack : v.ain);
            slv_rd   = v.cmd == 2'd2;
            slv_byte = v.sbyte;
            slv_ack  = v.sack;
            sb_en    = 1'b1;
            -> slv_kick;
        end
        @(posedge clk);
        @(negedge clk);
        bus.inp_en = 1'b0;
        n = 1;
        while (!bus.out_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        sb_en = 1'b0;
        checks++;
        if (n < v.elat - tol || n > v.elat + tol) begin
            errors++;
            $display("FAIL latency cmd %0d: got %0d want %0d", v.cmd, n, v.elat);
        end
        chk("out_err", bus.out_err, v.eerr);
        chk("out_busy", bus.out_busy, v.ebusy);
        chk("out_data", bus.out_data, v.edata);
        chk("out_ack", bus.out_ack, v.eack);
        chk("scl_pulses", obsq.size(), expq.size());
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            chk("sda_bit", o, e);
        end
        if (v.eerr) chk("no_edges", edges - e0, 0);
        else begin
            chk("starts", starts - s0, v.cmd == 2'd0);
            chk("stops", stops - p0, v.cmd == 2'd3);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s0, extra;
        vec_t v;
        checks = 0; errors = 0;
        scl_slv = 1'b0; slv_rd = 1'b0; slv_ack = 1'b0; slv_byte = 8'h00; sb_en = 1'b0;
        bus.inp_cmd = 2'd0; bus.inp_data = 8'h00; bus.inp_ack = 1'b0; bus.inp_en = 1'b0;
        vecs[0]  = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 17};
        vecs[1]  = '{2'd1, 8'hA4, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 145};
        vecs[2]  = '{2'd2, 8'h00, 1'b1, 1'b0, 8'h5C, 8'h5C, 1'b0, 1'b0, 1'b1, 145};
        vecs[3]  = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5C, 1'b0, 1'b0, 1'b0, 17};
        vecs[4]  = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5C, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5C, 1'b0, 1'b0, 1'b1, 17};
        vecs[6]  = '{2'd1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h5C, 1'b1, 1'b0, 1'b1, 145};
        vecs[7]  = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5C, 1'b1, 1'b0, 1'b1, 17};
        vecs[8]  = '{2'd2, 8'h00, 1'b0, 1'b0, 8'h3A, 8'h3A, 1'b1, 1'b0, 1'b1, 145};
        vecs[9]  = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3A, 1'b1, 1'b0, 1'b0, 17};
        vecs[10] = '{2'd1, 8'hC3, 1'b0, 1'b1, 8'h00, 8'h3A, 1'b1, 1'b1, 1'b0, 1};
        vecs[11] = '{2'd2, 8'h00, 1'b0, 1'b0, 8'h77, 8'h3A, 1'b1, 1'b1, 1'b0, 1};
        vecs[12] = '{2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3A, 1'b1, 1'b0, 1'b1, 17};
        vecs[13] = '{2'd1, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h3A, 1'b0, 1'b0, 1'b1, 145};
        vecs[14] = '{2'd2, 8'h00, 1'b1, 1'b0, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1, 145};
        vecs[15] = '{2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 17};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inp_rdy", bus.inp_rdy, 1);
        chk("rst_out_rdy", bus.out_rdy, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_out_busy", bus.out_busy, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_sda", sda, 1);
        chk("rst_scl", scl, 1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) run(vecs[i], 0);

        // A command offered while the engine is busy is dropped, not queued
        s0 = stops;
        bus.inp_cmd = 2'd0; bus.inp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inp_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_inp_rdy", bus.inp_rdy, 0);
        bus.inp_cmd = 2'd3; bus.inp_en = 1'b1;
        @(negedge clk);
        bus.inp_en = 1'b0;
        n = 6;
        while (!bus.out_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ign_latency", n, 17);
        chk("ign_busy", bus.out_busy, 1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_rdy) extra++;
        end
        chk("ign_no_extra_rdy", extra, 0);
        chk("ign_no_stop", stops - s0, 0);
        chk("ign_still_busy", bus.out_busy, 1);

`ifdef I2C_CLK_STRETCH_EN
        v = '{2'd1, 8'h96, 1'b0, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 185};
        fork
            begin
                scl_slv = 1'b1;
                repeat (40) @(negedge clk);
                scl_slv = 1'b0;
            end
        join_none
        run(v, 8);
`endif

        // Reset in the middle of bit 3 of a WRITE (bit value 0) must release both lines at once
        bus.inp_cmd = 2'd1; bus.inp_data = 8'hA4; bus.inp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inp_en = 1'b0;
        repeat (53) @(negedge clk);
        chk("bit3_sda_low", sda, 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_sda", sda, 1);
        chk("arst_scl", scl, 1);
        chk("arst_inp_rdy", bus.inp_rdy, 1);
        chk("arst_out_rdy", bus.out_rdy, 0);
        chk("arst_out_err", bus.out_err, 0);
        chk("arst_out_busy", bus.out_busy, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_ack", bus.out_ack, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", bus.out_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
